nd_1ton_rt: RTL and testbench



---
 rtl/nd_1ton_rt.sv | 176 +++++++++++++++++
 tb/tb_nd_1ton_rt.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nd_1ton_rt.sv
// One-input, N-output routing node: classifies each incoming word against ascending
// bounds, queues it in a per-channel FIFO and forwards it over a 4-phase handshake.
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif

module nd_1ton_rt #(
    parameter int NUM_OUT    = 2,
    parameter int DSZ        = `NS_DATA_SIZE,
    parameter logic [(NUM_OUT-1)*DSZ-1:0] BOUNDS = ((NUM_OUT-1)*DSZ)'(23),
    parameter int FIFO_DEPTH = 4,
    parameter int SYNC_IN    = 1,
    parameter int CSZ        = 8
) (
    input  logic                   i_clk,
    input  logic                   reset,
    output logic                   ready,
    input  logic                   rcv0_req,
    input  logic [DSZ-1:0]         rcv0_dat,
    output logic                   rcv0_ack,
    output logic [NUM_OUT-1:0]     snd_req,
    output logic [NUM_OUT*DSZ-1:0] snd_dat,
    input  logic [NUM_OUT-1:0]     snd_ack,
    output logic [NUM_OUT*CSZ-1:0] o_cnt,
    output logic                   o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic {RX_IDLE = 1'b0, RX_ACK = 1'b1} rx_state_t;
    // TX_REQ is the only state with bit 0 set, so snd_req is a bare flop output.
    typedef enum logic [1:0] {TX_IDLE = 2'b00, TX_REQ = 2'b01, TX_REL = 2'b10} tx_state_t;

    logic               req_s;
    logic [NUM_OUT-1:0] ack_s;

    generate
        if (SYNC_IN != 0) begin : g_sync
            logic               req_meta, req_sync;
            logic [NUM_OUT-1:0] ack_meta, ack_sync;
            always_ff @(posedge i_clk or posedge reset) begin
                if (reset) begin
                    req_meta <= 1'b0;
                    req_sync <= 1'b0;
                    ack_meta <= '0;
                    ack_sync <= '0;
                end else begin
                    req_meta <= rcv0_req;
                    req_sync <= req_meta;
                    ack_meta <= snd_ack;
                    ack_sync <= ack_meta;
                end
            end
            assign req_s = req_sync;
            assign ack_s = ack_sync;
        end else begin : g_nosync
            assign req_s = rcv0_req;
            assign ack_s = snd_ack;
        end
    endgenerate

    rx_state_t          rx_state, rx_next;
    tx_state_t          tx_state [NUM_OUT];
    tx_state_t          tx_next  [NUM_OUT];
    logic [AW:0]        wr_ptr   [NUM_OUT];
    logic [AW:0]        rd_ptr   [NUM_OUT];
    logic [DSZ-1:0]     mem      [NUM_OUT][FIFO_DEPTH];
    logic [DSZ-1:0]     head     [NUM_OUT];
    logic [NUM_OUT-1:0] full, empty, pop, load, push_vec;
    logic [TW-1:0]      target;
    logic               push, can_push;

    // Target channel = number of bounds the word reaches or exceeds.
    always_comb begin
        target = '0;
        for (int b = 0; b < NUM_OUT - 1; b++) begin
            if (rcv0_dat >= BOUNDS[b*DSZ +: DSZ])
                target = target + TW'(1);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            empty[k] = (wr_ptr[k] == rd_ptr[k]);
            full[k]  = (wr_ptr[k][AW] != rd_ptr[k][AW]) &&
                       (wr_ptr[k][AW-1:0] == rd_ptr[k][AW-1:0]);
            head[k]  = mem[k][rd_ptr[k][AW-1:0]];
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign can_push = !full[target] || pop[target];

    always_comb begin
        rx_next = rx_state;
        push    = 1'b0;
        case (rx_state)
            RX_IDLE: if (req_s && can_push) begin
                push    = 1'b1;
                rx_next = RX_ACK;
            end
            RX_ACK:  if (!req_s) rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        push_vec = '0;
        for (int k = 0; k < NUM_OUT; k++)
            push_vec[k] = push && (target == TW'(k));
    end

    always_comb begin
        pop  = '0;
        load = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            tx_next[k] = tx_state[k];
            case (tx_state[k])
                TX_IDLE: if (!empty[k] && !ack_s[k]) begin
                    load[k]    = 1'b1;
                    tx_next[k] = TX_REQ;
                end
                TX_REQ: if (ack_s[k]) begin
                    pop[k]     = 1'b1;
                    tx_next[k] = TX_REL;
                end
                TX_REL:  if (!ack_s[k]) tx_next[k] = TX_IDLE;
                default: tx_next[k] = TX_IDLE;
            endcase
        end
    end

    // NOTE: the storage array is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_OUT; k++) begin
            if (push_vec[k]) mem[k][wr_ptr[k][AW-1:0]] <= rcv0_dat;
        end
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            ready    <= 1'b0;
            rx_state <= RX_IDLE;
            snd_dat  <= '0;
            o_cnt    <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                tx_state[k] <= TX_IDLE;
                wr_ptr[k]   <= '0;
                rd_ptr[k]   <= '0;
            end
        end else begin
            ready    <= 1'b1;
            rx_state <= rx_next;
            for (int k = 0; k < NUM_OUT; k++) begin
                tx_state[k] <= tx_next[k];
                if (push_vec[k]) wr_ptr[k] <= wr_ptr[k] + (AW+1)'(1);
                if (pop[k]) begin
                    rd_ptr[k]             <= rd_ptr[k] + (AW+1)'(1);
                    o_cnt[k*CSZ +: CSZ]   <= o_cnt[k*CSZ +: CSZ] + CSZ'(1);
                end
                if (load[k]) snd_dat[k*DSZ +: DSZ] <= head[k];
            end
        end
    end

    always_comb begin
        snd_req = '0;
        for (int k = 0; k < NUM_OUT; k++)
            snd_req[k] = tx_state[k][0];
    end

    assign rcv0_ack = (rx_state == RX_ACK);
    assign o_busy   = (~empty != '0) || (rx_state != RX_IDLE);

endmodule

// File: tb/tb_nd_1ton_rt.sv
// Bench for nd_1ton_rt: 3 channels, bounds 23/40, synchronised inputs, handshake
// source and sinks, and a queue-based routing model that predicts every delivery.
module tb_nd_1ton_rt;

    localparam int N     = 3;
    localparam int DSZ   = 8;
    localparam int CSZ   = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ready;
    logic             rcv0_req = 1'b0;
    logic [DSZ-1:0]   rcv0_dat = '0;
    logic             rcv0_ack;
    logic [N-1:0]     snd_req;
    logic [N*DSZ-1:0] snd_dat;
    logic [N-1:0]     snd_ack = '0;
    logic [N*CSZ-1:0] o_cnt;
    logic             o_busy;

    int         checks = 0;
    int         errors = 0;
    bit         stall [N];
    bit         slow = 1'b0;
    logic [7:0] exp_q [N][$];
    int         exp_cnt [N];
    int         rx_cnt [N];

    always #5 clk = ~clk;

    nd_1ton_rt #(
        .NUM_OUT   (N),
        .DSZ       (DSZ),
        .BOUNDS    ({8'd40, 8'd23}),
        .FIFO_DEPTH(DEPTH),
        .SYNC_IN   (1),
        .CSZ       (CSZ)
    ) dut (
        .i_clk   (clk),
        .reset   (rst),
        .ready   (ready),
        .rcv0_req(rcv0_req),
        .rcv0_dat(rcv0_dat),
        .rcv0_ack(rcv0_ack),
        .snd_req (snd_req),
        .snd_dat (snd_dat),
        .snd_ack (snd_ack),
        .o_cnt   (o_cnt),
        .o_busy  (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int route(input logic [7:0] w);
        int         t = 0;
        logic [7:0] bnd [2] = '{8'd23, 8'd40};
        foreach (bnd[i]) if (w >= bnd[i]) t++;
        return t;
    endfunction

    task automatic push_model(input logic [7:0] w);
        int t = route(w);
        exp_q[t].push_back(w);
        exp_cnt[t]++;
    endtask

    // Sinks: acknowledge on the falling edge and score the delivered word.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                snd_ack[k] = 1'b0;
            end else if (snd_req[k] && !snd_ack[k] && !stall[k] &&
                         (!slow || $urandom_range(0, 2) == 0)) begin
                snd_ack[k] = 1'b1;
                rx_cnt[k]++;
                check($sformatf("ch%0d_expected_word", k), 32'(exp_q[k].size() != 0), 1);
                if (exp_q[k].size() != 0)
                    check($sformatf("ch%0d_data", k), 32'(snd_dat[k*DSZ +: DSZ]), 32'(exp_q[k].pop_front()));
            end else if (!snd_req[k] && snd_ack[k]) begin
                snd_ack[k] = 1'b0;
            end
        end
    end

    task automatic start_req(input logic [7:0] w);
        @(negedge clk);
        rcv0_dat = w;
        rcv0_req = 1'b1;
    endtask

    task automatic wait_ack(input int max, output int edges);
        edges = 0;
        while (!rcv0_ack && edges < max) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic finish_req();
        int n = 0;
        @(negedge clk);
        rcv0_req = 1'b0;
        while (rcv0_ack && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ack_release", 32'(rcv0_ack), 0);
    endtask

    task automatic send(input logic [7:0] w);
        int e;
        start_req(w);
        wait_ack(60, e);
        check("send_ack", 32'(rcv0_ack), 1);
        if (rcv0_ack) push_model(w);
        finish_req();
    endtask

    task automatic drain();
        int n = 0;
        while ((o_busy || snd_req != '0 || snd_ack != '0) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("drain_busy", 32'(o_busy), 0);
        for (int k = 0; k < N; k++) begin
            check($sformatf("cnt%0d", k), 32'(o_cnt[k*CSZ +: CSZ]), 32'(exp_cnt[k] % 256));
            check($sformatf("q%0d_empty", k), 32'(exp_q[k].size()), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         e, b0, b1;
        logic [7:0] w, bp_first;
        logic [7:0] route_vec [6] = '{8'd0, 8'd22, 8'd23, 8'd39, 8'd40, 8'd255};

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 0);
        check("rst_ack", 32'(rcv0_ack), 0);
        check("rst_snd_req", 32'(snd_req), 0);
        check("rst_snd_dat", 32'(snd_dat), 0);
        check("rst_cnt", 32'(o_cnt), 0);
        check("rst_busy", 32'(o_busy), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("ready_first_edge", 32'(ready), 1);

        // Latency: request set before edge E, ack expected at E+2, snd_req at E+3.
        repeat (3) @(negedge clk);
        start_req(8'd5);
        wait_ack(10, e);
        check("lat_ack_edge", 32'(e), 3);
        if (rcv0_ack) push_model(8'd5);
        check("lat_snd_req_low", 32'(snd_req[0]), 0);
        @(posedge clk); #1;
        check("lat_snd_req", 32'(snd_req[0]), 1);
        check("lat_snd_dat", 32'(snd_dat[7:0]), 5);
        finish_req();
        drain();

        foreach (route_vec[i]) send(route_vec[i]);
        drain();

        // Backpressure: sink 0 stalled, fifth word must not be acknowledged.
        b0 = rx_cnt[0];
        stall[0] = 1'b1;
        bp_first = 8'($urandom_range(0, 22));
        send(bp_first);
        for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 22)));
        w = 8'($urandom_range(0, 22));
        start_req(w);
        wait_ack(30, e);
        check("bp_blocked", 32'(rcv0_ack), 0);
        check("bp_ready", 32'(ready), 1);
        check("bp_head", 32'(snd_dat[7:0]), 32'(bp_first));
        stall[0] = 1'b0;
        wait_ack(60, e);
        check("bp_accept", 32'(rcv0_ack), 1);
        if (rcv0_ack) push_model(w);
        finish_req();
        drain();
        check("bp_delivered", 32'(rx_cnt[0] - b0), 5);

        // Independence: stalled sink 1 does not hold back channel 0.
        b0 = rx_cnt[0];
        b1 = rx_cnt[1];
        stall[1] = 1'b1;
        send(8'd3);
        send(8'd30);
        send(8'd5);
        repeat (20) @(posedge clk);
        #1;
        check("ind_ch0", 32'(rx_cnt[0] - b0), 2);
        check("ind_ch1_held", 32'(rx_cnt[1] - b1), 0);
        check("ind_ch1_req", 32'(snd_req[1]), 1);
        check("ind_ch1_dat", 32'(snd_dat[15:8]), 30);
        stall[1] = 1'b0;
        drain();

        slow = 1'b1;
        for (int i = 0; i < 60; i++) send(8'($urandom_range(0, 255)));
        drain();
        slow = 1'b0;

        b0 = exp_cnt[2];
        for (int i = 0; i < 257; i++) send(8'($urandom_range(40, 255)));
        drain();
        check("wrap_cnt2", 32'(o_cnt[23:16]), 32'((b0 + 257) % 256));

        // Reset while channel 1 sits in TX_REQ with two words queued.
        stall[1] = 1'b1;
        send(8'd25);
        send(8'd26);
        repeat (5) @(posedge clk);
        #1;
        check("mid_in_req", 32'(snd_req[1]), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_snd_req", 32'(snd_req), 0);
        check("mid_cnt", 32'(o_cnt), 0);
        check("mid_ack", 32'(rcv0_ack), 0);
        check("mid_ready", 32'(ready), 0);
        check("mid_busy", 32'(o_busy), 0);
        for (int k = 0; k < N; k++) begin
            exp_q[k].delete();
            exp_cnt[k] = 0;
        end
        stall[1] = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("post_ready", 32'(ready), 1);
        check("post_busy", 32'(o_busy), 0);
        repeat (5) @(posedge clk);
        #1;
        check("post_no_req", 32'(snd_req), 0);
        send(8'd50);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
